// File: rtl/banner_btn_ctrl.sv
// banner_btn_ctrl: debounces the run/stop and direction pushbuttons into toggled levels plus one-cycle ticks.
// Define BANNER_BTN_SYNC_EN to insert a two-flop synchronizer on each raw button input.

module banner_btn_debounce #(
    parameter int DB_TICKS = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic p,
    output logic level,
    output logic tick
);
    // state     | meaning
    // ----------+-------------------------------------------------
    // IDLE      | stable released, waiting for a press
    // CHK_PRESS | press seen, counting stable pressed samples
    // HELD      | stable pressed, no repeat while held
    // CHK_REL   | release seen, counting stable released samples

    localparam int CW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHK_PRESS = 2'd1,
        HELD      = 2'd2,
        CHK_REL   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          tick_q, tick_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (p) begin
                    state_d = CHK_PRESS;
                    cnt_d   = '0;
                end
            end
            CHK_PRESS: begin
                if (!p) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    tick_d  = 1'b1;
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!p) begin
                    state_d = CHK_REL;
                    cnt_d   = '0;
                end
            end
            CHK_REL: begin
                // a bounce back to pressed returns to HELD without a new tick
                if (p) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            tick_q  <= tick_d;
        end
    end

    assign level = level_q;
    assign tick  = tick_q;

endmodule

module banner_btn_ctrl #(
    parameter int DB_TICKS       = 1_000_000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_en_in,
    input  logic btn_dir_in,
    output logic en,
    output logic dir,
    output logic en_tick,
    output logic dir_tick
);
    localparam logic RELEASED = BTN_ACTIVE_LOW;

    logic en_raw, dir_raw;
    logic p_en, p_dir;

`ifdef BANNER_BTN_SYNC_EN
    logic [1:0] en_sync_q, en_sync_d;
    logic [1:0] dir_sync_q, dir_sync_d;

    always_comb begin
        en_sync_d  = {en_sync_q[0], btn_en_in};
        dir_sync_d = {dir_sync_q[0], btn_dir_in};
    end

    // reset to the released level so a reset never looks like a press edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sync_q  <= {2{RELEASED}};
            dir_sync_q <= {2{RELEASED}};
        end else begin
            en_sync_q  <= en_sync_d;
            dir_sync_q <= dir_sync_d;
        end
    end

    assign en_raw  = en_sync_q[1];
    assign dir_raw = dir_sync_q[1];
`else
    assign en_raw  = btn_en_in;
    assign dir_raw = btn_dir_in;
`endif

    assign p_en  = en_raw ^ RELEASED;
    assign p_dir = dir_raw ^ RELEASED;

    banner_btn_debounce #(
        .DB_TICKS(DB_TICKS)
    ) u_db_en (
        .clk  (clk),
        .rst  (rst),
        .p    (p_en),
        .level(en),
        .tick (en_tick)
    );

    banner_btn_debounce #(
        .DB_TICKS(DB_TICKS)
    ) u_db_dir (
        .clk  (clk),
        .rst  (rst),
        .p    (p_dir),
        .level(dir),
        .tick (dir_tick)
    );

endmodule
